// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor
// from the shifted partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial = {r, q[WIDTH-1]};
        diff = trial - {1'b0, d};
        // The partial remainder stays below the divisor, so WIDTH bits hold it.
        r_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/seq_divider_32bit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU beside the EX ALU.
// Operands are captured at start; sign fix-up happens after the loop.
module seq_divider_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_kill,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    div_state_e       state;
    logic [1:0]       op_q;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;

    logic             in_signed;
    logic             in_rem;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             sign_ovf;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_result;

    always_comb begin
        in_signed = op_is_signed(i_op);
        in_rem = op_is_rem(i_op);
        a_abs = (in_signed && i_a[WIDTH-1]) ? -i_a : i_a;
        b_abs = (in_signed && i_b[WIDTH-1]) ? -i_b : i_b;
        div_zero = (i_b == '0);
        sign_ovf = in_signed && (i_a == MIN_NEG) && (i_b == '1);
    end

    always_comb begin
        q_fix = neg_q ? -q_q : q_q;
        r_fix = neg_r ? -r_q : r_q;
        fix_result = q_fix;
        unique case (op_q)
            OP_DIV:  fix_result = q_fix;
            OP_DIVU: fix_result = q_q;
            OP_REM:  fix_result = r_fix;
            OP_REMU: fix_result = r_q;
        endcase
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (b_q),
        .r_next (r_nxt),
        .q_next (q_nxt)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            count    <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_kill) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_start) begin
                            op_q  <= i_op;
                            neg_q <= in_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                            neg_r <= in_signed && i_a[WIDTH-1];
                            b_q   <= b_abs;
                            r_q   <= '0;
                            q_q   <= a_abs;
                            count <= '0;
                            if (div_zero) begin
                                o_result <= in_rem ? i_a : '1;
                                o_valid  <= 1'b1;
                                state    <= DONE;
                            end else if (sign_ovf) begin
                                o_result <= in_rem ? '0 : MIN_NEG;
                                o_valid  <= 1'b1;
                                state    <= DONE;
                            end else begin
                                o_busy <= 1'b1;
                                state  <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        r_q   <= r_nxt;
                        q_q   <= q_nxt;
                        count <= count + 1'b1;
                        if (count == LAST_IT) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        o_result <= fix_result;
                        o_valid  <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
